// File: rtl/ramb4_port_arbiter.sv
// ramb4_port_arbiter: shares one synchronous RAMB4 port (512x8) between two
// requesters. Arbitration is round-robin with the previous winner masked for
// one cycle; every access is issued from registers, and read data comes back
// to the requester that issued it, with a one-cycle DV strobe.
// Optional build macro: RAMB4_ARB_FIXED_PRI_EN switches to fixed priority
// with requester 0 first. The one-cycle mask of the previous winner still
// applies in that mode.
//
// Handshake: REQx is a level valid held with WEx/ADDRx/DIx until GNTx pulses.
// GNTx is the ready/accept strobe, and the access is on the RAM in that same
// cycle. Request fields may change only in the cycle after GNTx. A REQx still
// high in that cycle is a new request. Reads complete with a DVx pulse three
// cycles after the cycle whose REQx sample won arbitration.
module ramb4_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DI0,
  input  logic              REQ1,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DI1,
  output logic              GNT0,
  output logic [DATA_W-1:0] DO0,
  output logic              DV0,
  output logic              GNT1,
  output logic [DATA_W-1:0] DO1,
  output logic              DV1,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_RST,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DI,
  input  logic [DATA_W-1:0] RAM_DO,
  output logic              BUSY
);

  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_di_q, ram_di_d;
  logic              rd2_vld_q, rd2_vld_d;
  logic              rd2_tag_q, rd2_tag_d;
  logic [1:0]        dv_q, dv_d;
  logic [DATA_W-1:0] do0_q, do0_d;
  logic [DATA_W-1:0] do1_q, do1_d;

  logic elig0, elig1, win0, win1;
  logic rd1_vld;

  // Arbitration: the requester showing GNT this cycle is masked, because its
  // REQ is still the request that was just accepted.
  always_comb begin
    elig0 = REQ0 & ~gnt_q[0];
    elig1 = REQ1 & ~gnt_q[1];
`ifdef RAMB4_ARB_FIXED_PRI_EN
    win0  = elig0;
`else
    win0  = elig0 & (~elig1 | last_q);
`endif
    win1  = elig1 & ~win0;
  end

  // Issue stage: register the winner's access. When idle, address and data keep their values.
  always_comb begin
    gnt_d      = {win1, win0};
    ram_en_d   = win0 | win1;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_di_d   = ram_di_q;
    last_d     = last_q;
    if (win0) begin
      ram_we_d   = WE0;
      ram_addr_d = ADDR0;
      ram_di_d   = DI0;
      last_d     = 1'b0;
    end else if (win1) begin
      ram_we_d   = WE1;
      ram_addr_d = ADDR1;
      ram_di_d   = DI1;
      last_d     = 1'b1;
    end
  end

  // Read return: a read on the port now has its data on RAM_DO next cycle.
  // That data is captured into the owner's DO register.
  always_comb begin
    rd1_vld   = ram_en_q & ~ram_we_q;
    rd2_vld_d = rd1_vld;
    rd2_tag_d = gnt_q[1];
    dv_d[0]   = rd2_vld_q & ~rd2_tag_q;
    dv_d[1]   = rd2_vld_q & rd2_tag_q;
    do0_d     = dv_d[0] ? RAM_DO : do0_q;
    do1_d     = dv_d[1] ? RAM_DO : do1_q;
  end

  // State registers. Reset clears the pipeline, so in-flight reads are dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q      <= 2'b00;
      last_q     <= 1'b1;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_di_q   <= '0;
      rd2_vld_q  <= 1'b0;
      rd2_tag_q  <= 1'b0;
      dv_q       <= 2'b00;
      do0_q      <= '0;
      do1_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      rd2_vld_q  <= rd2_vld_d;
      rd2_tag_q  <= rd2_tag_d;
      dv_q       <= dv_d;
      do0_q      <= do0_d;
      do1_q      <= do1_d;
    end
  end

  assign GNT0     = gnt_q[0];
  assign GNT1     = gnt_q[1];
  assign DV0      = dv_q[0];
  assign DV1      = dv_q[1];
  assign DO0      = do0_q;
  assign DO1      = do1_q;
  assign RAM_EN   = ram_en_q;
  assign RAM_WE   = ram_we_q;
  assign RAM_RST  = 1'b0;
  assign RAM_ADDR = ram_addr_q;
  assign RAM_DI   = ram_di_q;
  assign BUSY     = rd1_vld | rd2_vld_q;

endmodule

// File: tb/tb_ramb4_port_arbiter.sv
// tb_ramb4_port_arbiter: drives two requesters against a behavioural RAMB4
// port model. Every cycle it compares all outputs with a transaction-level
// reference. Honours RAMB4_ARB_FIXED_PRI_EN when defined.
module tb_ramb4_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 8;

  logic          clk, rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] di0, di1;
  logic          gnt0, gnt1, dv0, dv1, ram_en, ram_we, ram_rst, busy;
  logic [DW-1:0] do0, do1, ram_di, ram_do;
  logic [AW-1:0] ram_addr;

  ramb4_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .WE0(we0), .ADDR0(addr0), .DI0(di0),
    .REQ1(req1), .WE1(we1), .ADDR1(addr1), .DI1(di1),
    .GNT0(gnt0), .DO0(do0), .DV0(dv0),
    .GNT1(gnt1), .DO1(do1), .DV1(dv1),
    .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_RST(ram_rst),
    .RAM_ADDR(ram_addr), .RAM_DI(ram_di), .RAM_DO(ram_do),
    .BUSY(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  function automatic logic [DW-1:0] pre_val(int i);
    return 8'((i * 37 + 11) ^ (i >> 2));
  endfunction

  // RAM port model: synchronous, registered DO, write-first
  logic [DW-1:0] ram_mem [512];
  initial begin
    for (int i = 0; i < 512; i++) ram_mem[i] = pre_val(i);
    ram_do = '0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) begin
          ram_mem[ram_addr] = ram_di;
          ram_do <= ram_di;
        end else begin
          ram_do <= ram_mem[ram_addr];
        end
      end
    end
  end

  // reference model and requester state
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
  } op_t;

  op_t           ops0[$], ops1[$];
  op_t           cur [2];
  logic          act [2];
  logic          rnd_gap;
  logic [DW-1:0] ref_mem [512];
  logic [1:0]    e_gnt, p_gnt, e_dv;
  logic          e_en, e_we, e_busy, last_m;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_di;
  logic [DW-1:0] e_do [2];
  int            p_due[$];
  int            p_who[$];
  logic [DW-1:0] exp_q[$];
  int            cyc;
  int            checks, failures;

  function automatic op_t mk(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.di = d;
    return o;
  endfunction

  // bit layout: gnt[40:39] dv[38:37] do1[36:29] do0[28:21] en we rst addr[17:9] di[8:1] busy
  function automatic logic [40:0] obs_now();
    return {gnt1, gnt0, dv1, dv0, do1, do0, ram_en, ram_we, ram_rst, ram_addr, ram_di, busy};
  endfunction

  function automatic logic [40:0] exp_now();
    return {e_gnt, e_dv, e_do[1], e_do[0], e_en, e_we, 1'b0, e_addr, e_di, e_busy};
  endfunction

  task automatic drive_inputs();
    req0 = act[0]; we0 = cur[0].we; addr0 = cur[0].addr; di0 = cur[0].di;
    req1 = act[1]; we1 = cur[1].we; addr1 = cur[1].addr; di1 = cur[1].di;
  endtask

  task automatic model_reset();
    e_gnt = '0; p_gnt = '0; e_dv = '0; e_en = 0; e_we = 0; e_busy = 0;
    e_addr = '0; e_di = '0; e_do[0] = '0; e_do[1] = '0; last_m = 1'b1;
    p_due.delete(); p_who.delete(); exp_q.delete();
    ops0.delete(); ops1.delete();
    act[0] = 0; act[1] = 0; cur[0] = '0; cur[1] = '0;
    drive_inputs();
  endtask

  // driver tasks: one cycle of requesters plus reference; called at cycle start (posedge+1)
  task automatic step(output logic [40:0] o, output logic [40:0] e);
    int w;
    logic el0, el1;
    e_dv = '0;
    for (int i = p_due.size() - 1; i >= 0; i--) begin
      if (p_due[i] == cyc) begin
        e_dv[p_who[i]] = 1'b1;
        e_do[p_who[i]] = exp_q[i];
        p_due.delete(i); p_who.delete(i); exp_q.delete(i);
      end
    end
    e_busy = 0;
    foreach (p_due[i]) if (p_due[i] - 2 <= cyc) e_busy = 1;
    o = obs_now();
    e = exp_now();
    // a request accepted last cycle may now be replaced or dropped
    if (p_gnt[0]) act[0] = 0;
    if (p_gnt[1]) act[1] = 0;
    if (!act[0] && ops0.size() > 0 && !(rnd_gap && $urandom_range(0, 2) == 0)) begin
      cur[0] = ops0.pop_front(); act[0] = 1;
    end
    if (!act[1] && ops1.size() > 0 && !(rnd_gap && $urandom_range(0, 2) == 0)) begin
      cur[1] = ops1.pop_front(); act[1] = 1;
    end
    drive_inputs();
    // winner of this cycle issues next cycle
    el0 = act[0] && !e_gnt[0];
    el1 = act[1] && !e_gnt[1];
    w = -1;
`ifdef RAMB4_ARB_FIXED_PRI_EN
    if (el0) w = 0; else if (el1) w = 1;
`else
    if (el0 && el1) w = (last_m == 1'b1) ? 0 : 1;
    else if (el0) w = 0;
    else if (el1) w = 1;
`endif
    p_gnt = e_gnt;
    e_gnt = '0; e_en = 0; e_we = 0;
    if (w >= 0) begin
      e_gnt[w] = 1'b1; e_en = 1; e_we = cur[w].we;
      e_addr = cur[w].addr; e_di = cur[w].di; last_m = w[0];
      if (cur[w].we) ref_mem[cur[w].addr] = cur[w].di;
      else begin
        p_due.push_back(cyc + 3); p_who.push_back(w); exp_q.push_back(ref_mem[cur[w].addr]);
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [40:0] o, e;
    rst = 1; rnd_gap = 0; cyc = 0;
    model_reset();
    #12;
    o = obs_now();
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", o); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      step(o, e); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, o, e); end
    end
  endtask

  task automatic test_write_read();
    logic [40:0] o, e;
    ops0.push_back(mk(1'b1, 9'h010, 8'hA5));
    ops0.push_back(mk(1'b0, 9'h010, 8'h00));
    for (int i = 0; i < 10; i++) begin
      step(o, e); checks++;
      if (o !== e) begin failures++; $display("FAIL write_read cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (e[37]) begin
        checks++;
        if (o[28:21] !== 8'hA5) begin failures++; $display("FAIL write_read_do0 got=%h exp=a5", o[28:21]); end
      end
    end
  endtask

  task automatic test_alternating();
    logic [40:0] o, e;
    int n_dv0, n_dv1;
    n_dv0 = 0; n_dv1 = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ops0.push_back(mk(1'b0, 9'(i), 8'h00));
      ops1.push_back(mk(1'b0, 9'(9'h1FF - i), 8'h00));
    end
    for (int i = 0; i < 14; i++) begin
      step(o, e); checks++;
      if (o !== e) begin failures++; $display("FAIL alternating cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o[37]) n_dv0++;
      if (o[38]) n_dv1++;
    end
    checks++;
    if (n_dv0 !== 4 || n_dv1 !== 4) begin
      failures++; $display("FAIL alternating_dv_count got=%0d/%0d exp=4/4", n_dv0, n_dv1);
    end
  endtask

  task automatic test_single_hold();
    logic [40:0] o, e;
    int n_g1, n_consec;
    logic prev;
    n_g1 = 0; n_consec = 0; prev = 0;
    do_reset();
    for (int i = 0; i < 3; i++) ops1.push_back(mk(1'b0, 9'(9'h080 + i), 8'h00));
    for (int i = 0; i < 10; i++) begin
      step(o, e); checks++;
      if (o !== e) begin failures++; $display("FAIL single_hold cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o[40]) begin n_g1++; if (prev) n_consec++; end
      prev = o[40];
    end
    checks++;
    if (n_g1 !== 3 || n_consec !== 0) begin
      failures++; $display("FAIL single_hold_grants got=%0d consec=%0d exp=3 consec=0", n_g1, n_consec);
    end
  endtask

  task automatic test_conflict();
    logic [40:0] o, e;
    logic [DW-1:0] d;
    d = 8'($urandom_range(0, 255));
    do_reset();
    ops0.push_back(mk(1'b1, 9'h020, d));
    ops1.push_back(mk(1'b0, 9'h020, 8'h00));
    for (int i = 0; i < 8; i++) begin
      step(o, e); checks++;
      if (o !== e) begin failures++; $display("FAIL conflict cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (e[38]) begin
        checks++;
        if (o[36:29] !== d) begin failures++; $display("FAIL conflict_do1 got=%h exp=%h", o[36:29], d); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [40:0] o, e;
    do_reset();
    ops0.push_back(mk(1'b0, 9'h055, 8'h00));
    for (int i = 0; i < 2; i++) begin
      step(o, e); checks++;
      if (o !== e) begin failures++; $display("FAIL mid_read_issue cyc=%0d got=%h exp=%h", cyc, o, e); end
    end
    // read is now in flight with its data on RAM_DO; reset asynchronously
    #1 rst = 1;
    #1 o = obs_now();
    checks++;
    if (o !== '0) begin failures++; $display("FAIL mid_reset_outputs got=%h exp=0", o); end
    model_reset();
    @(negedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    ops0.push_back(mk(1'b0, 9'h001, 8'h00));
    ops1.push_back(mk(1'b0, 9'h002, 8'h00));
    for (int i = 0; i < 8; i++) begin
      step(o, e); checks++;
      if (o !== e) begin failures++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (i == 1) begin
        checks++;
        if (o[40:39] !== 2'b01) begin failures++; $display("FAIL last_after_reset got=%b exp=01", o[40:39]); end
      end
    end
  endtask

  task automatic test_random();
    logic [40:0] o, e;
    do_reset();
    rnd_gap = 1;
    for (int i = 0; i < 80; i++) begin
      ops0.push_back(mk(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 9'(9'h1F8 + $urandom_range(0, 7)) : 9'($urandom_range(0, 7)),
                        8'($urandom_range(0, 255))));
      ops1.push_back(mk(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? 9'(9'h1F8 + $urandom_range(0, 7)) : 9'($urandom_range(0, 7)),
                        8'($urandom_range(0, 255))));
    end
    for (int i = 0; i < 400; i++) begin
      step(o, e); checks++;
      if (o !== e) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e); end
    end
    rnd_gap = 0;
  endtask

  // sequence and final report
  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = pre_val(i);
    test_reset();
    test_write_read();
    test_alternating();
    test_single_hold();
    test_conflict();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
